// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the pipelined arithmetic blocks.
// Holds the default single-precision field widths, the packed operand
// layout, the special result encodings and the rounding-mode selector.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  localparam fp_t FP_ZERO = '0;
  localparam fp_t FP_NAN  = '1;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } round_mode_e;

  // Exponent bias for an arbitrary exponent field width.
  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final floating-point stage: rounding, carry renormalisation, exception
// selection and packing. Purely combinational; the caller registers it.
//   zs_i      result sign
//   zero_i    an operand was zero/denormal; forces +0 without flags
//   exp_i     signed, biased, already-normalised exponent (EXP_W+2 bits)
//   man_i     normalised mantissa without hidden one
//   guard_i/round_i/sticky_i  bits below the mantissa LSB
//   z_o       packed {sign, exp, man}
//   ufw_o     underflow, result flushed to +0
//   ofw_o     overflow, result forced to all ones
module fp_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ROUND = 1
) (
  input  logic                    zs_i,
  input  logic                    zero_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [MAN_W-1:0]        man_i,
  input  logic                    guard_i,
  input  logic                    round_i,
  input  logic                    sticky_i,
  output logic [EXP_W+MAN_W:0]    z_o,
  output logic                    ufw_o,
  output logic                    ofw_o
);
  import fp_pkg::*;

  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
  localparam bit                    RNE      = (ROUND == int'(RND_RNE));

  logic                  inc;
  logic [MAN_W:0]        man_inc;
  logic [MAN_W-1:0]      man_r;
  logic signed [EW2-1:0] exp_r;

  always_comb begin
    inc = 1'b0;
    if (RNE) begin
      inc = guard_i & (round_i | sticky_i | man_i[0]);
    end
    man_inc = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
    exp_r   = exp_i;
    man_r   = man_inc[MAN_W-1:0];
    // All-ones mantissa rounded up: value becomes 2.0, so bump the exponent.
    if (man_inc[MAN_W]) begin
      exp_r = exp_i + EXP_ONE;
      man_r = '0;
    end

    z_o   = '0;
    ufw_o = 1'b0;
    ofw_o = 1'b0;
    if (zero_i) begin
      z_o = '0;
    end else if (exp_r <= EXP_ZERO) begin
      ufw_o = 1'b1;
    end else if (exp_r >= EXP_MAX) begin
      z_o   = '1;
      ofw_o = 1'b1;
    end else begin
      z_o = {zs_i, exp_r[EXP_W-1:0], man_r};
    end
  end

endmodule

// File: rtl/srmul_pipe.sv
// Three-stage pipelined floating-point multiplier z = a * b with
// valid/ready handshakes and a sideband tag carried alongside each pair.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for a, b, in_tag
//   a, b                 operands {sign, exp, man}
//   in_tag               sideband tag, returned unchanged with the result
//   out_valid/out_ready  output handshake for z, out_tag, ufw, ofw
//   z                    product
//   ufw, ofw             underflow-flushed / overflow flags
// S1 unpacks and multiplies, S2 normalises, S3 rounds and packs.
module srmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ROUND = 1,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   ufw,
  output logic                   ofw
);
  import fp_pkg::*;

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int PW  = 2 * (MAN_W + 1);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S   = EW2'(bias_of(EXP_W));
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;

  // Stage valids and handshake
  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic adv1, adv2, adv3;
  logic ld1, ld2, ld3;

  // S1 registers
  logic                  zs1_q, zs1_d;
  logic                  zero1_q, zero1_d;
  logic [PW-1:0]         prod1_q, prod1_d;
  logic signed [EW2-1:0] esum1_q, esum1_d;
  logic [TAG_W-1:0]      tag1_q;

  // S2 registers
  logic                  zs2_q, zero2_q;
  logic signed [EW2-1:0] exp2_q, exp2_d;
  logic [MAN_W-1:0]      man2_q, man2_d;
  logic                  g2_q, r2_q, s2_q;
  logic                  g2_d, r2_d, s2_d;
  logic [TAG_W-1:0]      tag2_q;

  // S3 registers
  logic [W-1:0]          z3_q, z3_d;
  logic                  ufw3_q, ufw3_d;
  logic                  ofw3_q, ofw3_d;
  logic [TAG_W-1:0]      tag3_q;

  // A stage may take new data when it is empty or its contents move on.
  always_comb begin
    adv3 = !v3_q | out_ready;
    adv2 = !v2_q | adv3;
    adv1 = !v1_q | adv2;
    ld1  = adv1 & in_valid;
    ld2  = adv2 & v1_q;
    ld3  = adv3 & v2_q;
    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q     : v2_q;
    v3_d = adv3 ? v2_q     : v3_q;
  end

  assign in_ready = adv1;

  // S1: sign, exponent sum, full mantissa product with hidden ones.
  logic [MAN_W:0]   ma, mb;
  logic [EXP_W-1:0] ea, eb;

  always_comb begin
    ea      = a[MAN_W +: EXP_W];
    eb      = b[MAN_W +: EXP_W];
    ma      = {1'b1, a[MAN_W-1:0]};
    mb      = {1'b1, b[MAN_W-1:0]};
    zs1_d   = a[W-1] ^ b[W-1];
    zero1_d = (ea == '0) | (eb == '0);
    prod1_d = PW'(ma) * PW'(mb);
    esum1_d = $signed({2'b00, ea}) + $signed({2'b00, eb});
  end

  // S2: product lies in [1,4); bring it to [1,2) and split off G/R/S.
  // norm drops the leading one, so its top bit is the first stored bit.
  logic [PW-2:0] norm;

  always_comb begin
    norm   = prod1_q[PW-1] ? prod1_q[PW-2:0] : {prod1_q[PW-3:0], 1'b0};
    exp2_d = esum1_q - BIAS_S + (prod1_q[PW-1] ? EXP_ONE : EXP_ZERO);
    man2_d = norm[PW-2 -: MAN_W];
    g2_d   = norm[PW-2-MAN_W];
    r2_d   = norm[PW-3-MAN_W];
    s2_d   = |norm[PW-4-MAN_W:0];
  end

  // S3: rounding and exception handling feed the output register.
  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .ROUND (ROUND)
  ) u_round_pack (
    .zs_i     (zs2_q),
    .zero_i   (zero2_q),
    .exp_i    (exp2_q),
    .man_i    (man2_q),
    .guard_i  (g2_q),
    .round_i  (r2_q),
    .sticky_i (s2_q),
    .z_o      (z3_d),
    .ufw_o    (ufw3_d),
    .ofw_o    (ofw3_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      zs1_q   <= 1'b0;
      zero1_q <= 1'b0;
      prod1_q <= '0;
      esum1_q <= '0;
      tag1_q  <= '0;
      zs2_q   <= 1'b0;
      zero2_q <= 1'b0;
      exp2_q  <= '0;
      man2_q  <= '0;
      g2_q    <= 1'b0;
      r2_q    <= 1'b0;
      s2_q    <= 1'b0;
      tag2_q  <= '0;
      z3_q    <= '0;
      ufw3_q  <= 1'b0;
      ofw3_q  <= 1'b0;
      tag3_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld1) begin
        zs1_q   <= zs1_d;
        zero1_q <= zero1_d;
        prod1_q <= prod1_d;
        esum1_q <= esum1_d;
        tag1_q  <= in_tag;
      end
      if (ld2) begin
        zs2_q   <= zs1_q;
        zero2_q <= zero1_q;
        exp2_q  <= exp2_d;
        man2_q  <= man2_d;
        g2_q    <= g2_d;
        r2_q    <= r2_d;
        s2_q    <= s2_d;
        tag2_q  <= tag1_q;
      end
      // Output register only changes on a load, so a stalled result holds.
      if (ld3) begin
        z3_q   <= z3_d;
        ufw3_q <= ufw3_d;
        ofw3_q <= ofw3_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign z         = z3_q;
  assign out_tag   = tag3_q;
  assign ufw       = ufw3_q;
  assign ofw       = ofw3_q;

endmodule

// File: tb/tb_srmul_pipe.sv
module tb_srmul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_t;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid, out_valid_t;
  logic        out_ready = 1'b1;
  logic [31:0] z, z_t;
  logic [3:0]  out_tag, out_tag_t;
  logic        ufw, ofw, ufw_t, ofw_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  srmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND(1), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(in_a), .b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .out_tag(out_tag), .ufw(ufw), .ofw(ofw));

  srmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND(0), .TAG_W(4)) u_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(in_a), .b(in_b), .in_tag(in_tag), .out_valid(out_valid_t),
    .out_ready(out_ready), .z(z_t), .out_tag(out_tag_t), .ufw(ufw_t), .ofw(ofw_t));

  typedef struct packed {
    logic [31:0] z_r;
    logic        u_r;
    logic        o_r;
    logic [31:0] z_t;
    logic        u_t;
    logic        o_t;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  logic last_acc = 1'b0;
  logic hold_prev = 1'b0;
  logic [31:0] hold_z;
  logic [3:0]  hold_tag;
  logic        hold_u, hold_o;
  logic [3:0]  tag_ctr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, scaled so the kept 24 bits are the
  // significand; rounding decided by comparing the discarded remainder
  // against one half ULP.
  function automatic void fmul_ref(input logic [31:0] a, input logic [31:0] b, input bit rne,
                                   output logic [31:0] zr, output logic uf, output logic of);
    int ea, eb, msb, sh, e;
    longint unsigned ma, mb, p, kept, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    zr = '0; uf = 1'b0; of = 1'b0;
    if (ea == 0 || eb == 0) return;
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    e    = ea + eb - 127 + (msb - 46);
    sh   = msb - 23;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    if (rne && (rem > half || (rem == half && kept[0]))) kept = kept + 1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e <= 0) uf = 1'b1;
    else if (e >= 255) begin
      zr = '1;
      of = 1'b1;
    end else zr = {a[31] ^ b[31], 8'(e), 23'(kept)};
  endfunction

  // Single compare process: scoreboard, twin agreement and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_acc  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      check("ready_twin", in_ready_t, in_ready);
      check("valid_twin", out_valid_t, out_valid);
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_z", z, hold_z);
        check("hold_tag", out_tag, hold_tag);
        check("hold_flags", {ufw, ofw}, {hold_u, hold_o});
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: z=%h tag=%0d with nothing outstanding", z, out_tag);
        end else begin
          check("z_rne", z, sb[0].z_r);
          check("ufw_rne", ufw, sb[0].u_r);
          check("ofw_rne", ofw, sb[0].o_r);
          check("tag", out_tag, sb[0].tag);
          check("z_trunc", z_t, sb[0].z_t);
          check("ufw_trunc", ufw_t, sb[0].u_t);
          check("ofw_trunc", ofw_t, sb[0].o_t);
          check("tag_trunc", out_tag_t, sb[0].tag);
          if (out_ready) void'(sb.pop_front());
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_z    = z;
      hold_tag  = out_tag;
      hold_u    = ufw;
      hold_o    = ofw;
      last_acc  = in_valid && in_ready;
      if (last_acc) begin
        exp_t e;
        fmul_ref(in_a, in_b, 1'b1, e.z_r, e.u_r, e.o_r);
        fmul_ref(in_a, in_b, 1'b0, e.z_t, e.u_t, e.o_t);
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
  end

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int r;
    r = int'($urandom_range(99));
    if (r < 3) e = 8'd0;
    else if (r < 60) e = 8'($urandom_range(157, 97));
    else e = 8'($urandom_range(254, 1));
    m = 23'($urandom);
    if ($urandom_range(99) < 25) m = m & 23'h7E0000;
    return {1'($urandom_range(1)), e, m};
  endfunction

  task automatic present_next();
    in_a     = rand_fp();
    in_b     = rand_fp();
    in_tag   = tag_ctr;
    tag_ctr  = tag_ctr + 4'd1;
    in_valid = 1'b1;
  endtask

  task automatic stream(input int n, input int vld_pct, input int rdy_pct);
    int acc = 0;
    int cyc = 0;
    in_valid = 1'b0;
    while (acc < n && cyc < 40 * n + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (in_valid && last_acc) acc++;
      if (!in_valid || last_acc) begin
        if (acc < n && int'($urandom_range(99)) < vld_pct) present_next();
        else in_valid = 1'b0;
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
    end
    in_valid = 1'b0;
    if (acc < n) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: accepted %0d of %0d", acc, n);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_empty", sb.size(), 0);
    check("drain_valid", out_valid, 1'b0);
  endtask

  task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ez,
                        input logic [31:0] ezt, input logic eu, input logic eo);
    logic [31:0] mz;
    logic mu, mo;
    logic [3:0] t;
    fmul_ref(a, b, 1'b1, mz, mu, mo);
    check("model_rne", {mz, mu, mo}, {ez, eu, eo});
    fmul_ref(a, b, 1'b0, mz, mu, mo);
    check("model_trunc", mz, ezt);
    t = tag_ctr;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    tag_ctr = tag_ctr + 4'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
    check("lit_z", z, ez);
    check("lit_flags", {ufw, ofw}, {eu, eo});
    check("lit_tag", out_tag, t);
    check("lit_z_trunc", z_t, ezt);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_z", z, 32'h0);
    check("rst_tag", out_tag, 4'h0);
    check("rst_flags", {ufw, ofw}, 2'b00);

    one_op(32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 1'b0, 1'b0);
    one_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 32'hC0C00000, 1'b0, 1'b0);
    one_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 1'b0, 1'b0);
    one_op(32'h3FC00001, 32'h3FC00001, 32'h40100002, 32'h40100001, 1'b0, 1'b0);
    one_op(32'h7F000000, 32'h7F000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    one_op(32'h00800000, 32'h00800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    one_op(32'h80800000, 32'h00800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    one_op(32'h00000000, 32'h7F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    drain();

    // Back-pressure: output stalled for five cycles.
    out_ready = 1'b0;
    acc = 0;
    present_next();
    repeat (5) begin
      @(posedge clk); #1;
      if (last_acc) begin
        acc++;
        present_next();
      end
    end
    check("stall_accepts", acc, 3);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc = 0;
    while (acc < 6 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (last_acc) begin
        acc++;
        if (acc < 6) present_next();
        else in_valid = 1'b0;
      end
    end
    check("release_accepts", acc, 6);
    drain();

    // Reset with a full pipeline.
    out_ready = 1'b0;
    acc = 0;
    cyc = 0;
    present_next();
    while (acc < 3 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (last_acc) begin
        acc++;
        if (acc < 3) present_next();
        else in_valid = 1'b0;
      end
    end
    @(posedge clk); #3;
    check("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b1);
    check("async_rst_z", z, 32'h0);
    check("async_rst_tag", out_tag, 4'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_stale", out_valid, 1'b0);
    end

    // Random traffic with throttled output.
    stream(10000, 80, 70);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
